// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared FSM state type and default timing constants for key conditioning
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/key_cond_channel.sv
// key_cond_channel: one key's synchronizer, debounce FSM and pulses; auto-repeat under KEY_COND_REPEAT_EN
module key_cond_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             pressed;
  logic             accept;
  logic             rep_fire;

  assign sync_d  = {sync_q[0], key_n};
  assign pressed = ~sync_q[1];

  // debounce FSM: a transition is accepted only after DEBOUNCE_CYCLES stable samples
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) state_d = IDLE;
        else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          accept  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        if (pressed) state_d = HELD;
        else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
    endcase
    level_d = state_d == HELD || state_d == RELEASE_WAIT;
    press_d = accept | rep_fire;
  end

  // state, counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_COND_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rcnt_q, rcnt_d;

  // repeat counter runs only while held and pressed; reloading after each repeat gives the period
  always_comb begin
    rep_fire = state_q == HELD && pressed && rcnt_q == RPT_LAST;
    rcnt_d   = state_q == PRESS_WAIT || state_d == IDLE ? '0 :
               state_q == HELD && pressed ? (rep_fire ? RPT_RELOAD : rcnt_q + 1'b1) : rcnt_q;
  end

  // repeat counter register
  always_ff @(posedge clock) begin
    if (reset) rcnt_q <= '0;
    else rcnt_q <= rcnt_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_step_conditioner.sv
// key_step_conditioner: debounced level and press/release pulses per key; auto-repeat with KEY_COND_REPEAT_EN
module key_step_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_press
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_cond_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .key_n      (key_n[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

  assign any_press = |key_press;

endmodule
